// File: rtl/id_operand_stage.sv
// Decode/operand stage: forwards operands, builds the immediate and branch target, and registers the result toward EXE.
// One-cycle latency. A load-use hazard or a stalled EXE drops in_ready, and flush kills the staged result.
module id_operand_stage #(
    parameter int DATA_W    = 32,
    parameter int RADDR_W   = 5,
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        i_inst,
    input  logic [DATA_W-1:0]  i_pc,
    input  logic               i_use_rs,
    input  logic               i_use_rt,
    input  logic               i_sext,
    input  logic               i_rd_or_rt,
    input  logic               i_branch,
    input  logic               i_bne,
    output logic [RADDR_W-1:0] ra,
    output logic [RADDR_W-1:0] rb,
    input  logic [DATA_W-1:0]  qa,
    input  logic [DATA_W-1:0]  qb,
    input  logic [RADDR_W-1:0] exe_reg,
    input  logic [RADDR_W-1:0] mem_reg,
    input  logic [RADDR_W-1:0] wb_reg,
    input  logic               exe_write_regfile,
    input  logic               mem_write_regfile,
    input  logic               wb_write_regfile,
    input  logic               exe_mem_to_regfile,
    input  logic [DATA_W-1:0]  exe_result,
    input  logic [DATA_W-1:0]  mem_result,
    input  logic [DATA_W-1:0]  wb_result,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_da,
    output logic [DATA_W-1:0]  out_db,
    output logic [DATA_W-1:0]  out_imm,
    output logic [DATA_W-1:0]  out_pc,
    output logic [RADDR_W-1:0] out_rn,
    output logic               branch_taken,
    output logic [DATA_W-1:0]  bpc,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic [RADDR_W-1:0] rs, rt, rn_d;
    logic [DATA_W-1:0]  da_d, db_d, imm_d;
    logic               hazard, xfer;

    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  da_q, db_q, imm_q, pc_q;
    logic [RADDR_W-1:0] rn_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign rs = RADDR_W'(i_inst[25:21]);
    assign rt = RADDR_W'(i_inst[20:16]);
    assign ra = rs;
    assign rb = rt;

    // Youngest producer wins; a load still in EXE never forwards (it stalls instead).
    function automatic logic [DATA_W-1:0] fwd(input logic [RADDR_W-1:0] addr,
                                              input logic [DATA_W-1:0]  rf);
        if (addr == '0)
            return '0;
        else if (exe_write_regfile && !exe_mem_to_regfile && exe_reg == addr)
            return exe_result;
        else if (mem_write_regfile && mem_reg == addr)
            return mem_result;
        else if (WB_BYPASS && wb_write_regfile && wb_reg == addr)
            return wb_result;
        else
            return rf;
    endfunction

    assign da_d  = fwd(rs, qa);
    assign db_d  = fwd(rt, qb);
    assign imm_d = {{(DATA_W-16){i_inst[15] & i_sext}}, i_inst[15:0]};
    assign rn_d  = i_rd_or_rt ? RADDR_W'(i_inst[15:11]) : RADDR_W'(i_inst[20:16]);
    assign bpc   = i_pc + DATA_W'(4) + (imm_d << 2);

    assign hazard = in_valid && exe_mem_to_regfile && exe_write_regfile && (exe_reg != '0) &&
                    ((i_use_rs && exe_reg == rs) || (i_use_rt && exe_reg == rt));

    assign in_ready     = reset && !hazard && (!valid_q || out_ready);
    assign xfer         = in_valid && in_ready;
    assign branch_taken = xfer && i_branch && ((da_d == db_d) ^ i_bne) && !flush;

    always_comb begin
        valid_d = valid_q;
        if (flush)
            valid_d = 1'b0;
        else if (xfer)
            valid_d = 1'b1;
        else if (out_ready)
            valid_d = 1'b0;
    end

    assign cnt_d = (hazard && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            da_q    <= '0;
            db_q    <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            rn_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            if (xfer && !flush) begin
                da_q  <= da_d;
                db_q  <= db_d;
                imm_q <= imm_d;
                pc_q  <= i_pc;
                rn_q  <= rn_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_da    = da_q;
    assign out_db    = db_q;
    assign out_imm   = imm_q;
    assign out_pc    = pc_q;
    assign out_rn    = rn_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage; a second instance with a 2-bit stall counter checks saturation.
module tb_id_operand_stage;

    logic        clk, reset, in_valid, out_ready, flush;
    logic [31:0] i_inst, i_pc, qa, qb, exe_result, mem_result, wb_result;
    logic        i_use_rs, i_use_rt, i_sext, i_rd_or_rt, i_branch, i_bne;
    logic [4:0]  exe_reg, mem_reg, wb_reg;
    logic        exe_write_regfile, mem_write_regfile, wb_write_regfile, exe_mem_to_regfile;

    logic        in_ready, out_valid, branch_taken;
    logic [4:0]  ra, rb, out_rn;
    logic [31:0] out_da, out_db, out_imm, out_pc, bpc;
    logic [15:0] stall_cnt;

    logic        in_ready2, out_valid2, branch_taken2;
    logic [4:0]  ra2, rb2, out_rn2;
    logic [31:0] out_da2, out_db2, out_imm2, out_pc2, bpc2;
    logic [1:0]  stall_cnt2;

    int n_cmp = 0;
    int n_fail = 0;

    id_operand_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .i_inst(i_inst), .i_pc(i_pc), .i_use_rs(i_use_rs), .i_use_rt(i_use_rt),
        .i_sext(i_sext), .i_rd_or_rt(i_rd_or_rt), .i_branch(i_branch), .i_bne(i_bne),
        .ra(ra), .rb(rb), .qa(qa), .qb(qb),
        .exe_reg(exe_reg), .mem_reg(mem_reg), .wb_reg(wb_reg),
        .exe_write_regfile(exe_write_regfile), .mem_write_regfile(mem_write_regfile),
        .wb_write_regfile(wb_write_regfile), .exe_mem_to_regfile(exe_mem_to_regfile),
        .exe_result(exe_result), .mem_result(mem_result), .wb_result(wb_result),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_da(out_da), .out_db(out_db), .out_imm(out_imm), .out_pc(out_pc),
        .out_rn(out_rn), .branch_taken(branch_taken), .bpc(bpc), .stall_cnt(stall_cnt)
    );

    id_operand_stage #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .i_inst(i_inst), .i_pc(i_pc), .i_use_rs(i_use_rs), .i_use_rt(i_use_rt),
        .i_sext(i_sext), .i_rd_or_rt(i_rd_or_rt), .i_branch(i_branch), .i_bne(i_bne),
        .ra(ra2), .rb(rb2), .qa(qa), .qb(qb),
        .exe_reg(exe_reg), .mem_reg(mem_reg), .wb_reg(wb_reg),
        .exe_write_regfile(exe_write_regfile), .mem_write_regfile(mem_write_regfile),
        .wb_write_regfile(wb_write_regfile), .exe_mem_to_regfile(exe_mem_to_regfile),
        .exe_result(exe_result), .mem_result(mem_result), .wb_result(wb_result),
        .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
        .out_da(out_da2), .out_db(out_db2), .out_imm(out_imm2), .out_pc(out_pc2),
        .out_rn(out_rn2), .branch_taken(branch_taken2), .bpc(bpc2), .stall_cnt(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
        return {6'd0, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; out_ready = 1; flush = 0;
        i_inst = 0; i_pc = 0; qa = 0; qb = 0;
        i_use_rs = 0; i_use_rt = 0; i_sext = 0; i_rd_or_rt = 0; i_branch = 0; i_bne = 0;
        exe_reg = 0; mem_reg = 0; wb_reg = 0;
        exe_write_regfile = 0; mem_write_regfile = 0; wb_write_regfile = 0; exe_mem_to_regfile = 0;
        exe_result = 0; mem_result = 0; wb_result = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 0;
        in_valid = 1; i_inst = mk(5'd7, 5'd9, 16'h0);
        #3;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_da !== 32'h0) begin n_fail++; $display("FAIL reset_out_da: got %h want 0", out_da); end
        n_cmp++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall_cnt: got %h want 0", stall_cnt); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (ra !== 5'd7 || rb !== 5'd9) begin n_fail++; $display("FAIL reset_ra_rb: got %0d/%0d want 7/9", ra, rb); end
        tick();
        tick();
        in_valid = 0;
        reset = 1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        in_valid = 1; i_pc = 32'h40;
        i_inst = mk(5'd3, 5'd0, 16'h8001); i_sext = 1; i_rd_or_rt = 1;
        qa = 5; exe_reg = 3; exe_write_regfile = 1; exe_result = 9;
        mem_reg = 3; mem_write_regfile = 1; mem_result = 7;
        wb_reg = 3; wb_result = 32'h33;
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_exe_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_da !== 32'd9) begin n_fail++; $display("FAIL fwd_exe_da: got %h want 9", out_da); end
        n_cmp++; if (out_db !== 32'd0) begin n_fail++; $display("FAIL fwd_r0_db: got %h want 0", out_db); end
        n_cmp++; if (out_imm !== 32'hFFFF8001) begin n_fail++; $display("FAIL imm_sext: got %h want ffff8001", out_imm); end
        n_cmp++; if (out_rn !== 5'd16) begin n_fail++; $display("FAIL rn_rd: got %0d want 16", out_rn); end
        n_cmp++; if (out_pc !== 32'h40) begin n_fail++; $display("FAIL out_pc: got %h want 40", out_pc); end
        exe_write_regfile = 0; i_sext = 0; i_rd_or_rt = 0; i_inst = mk(5'd3, 5'd6, 16'h8001);
        tick();
        n_cmp++; if (out_da !== 32'd7) begin n_fail++; $display("FAIL fwd_mem_da: got %h want 7", out_da); end
        n_cmp++; if (out_imm !== 32'h00008001) begin n_fail++; $display("FAIL imm_zext: got %h want 8001", out_imm); end
        n_cmp++; if (out_rn !== 5'd6) begin n_fail++; $display("FAIL rn_rt: got %0d want 6", out_rn); end
        mem_write_regfile = 0; wb_write_regfile = 1;
        tick();
        n_cmp++; if (out_da !== 32'h33) begin n_fail++; $display("FAIL fwd_wb_da: got %h want 33", out_da); end
        wb_write_regfile = 0;
        tick();
        n_cmp++; if (out_da !== 32'd5) begin n_fail++; $display("FAIL fwd_rf_da: got %h want 5", out_da); end
        clear_inputs();
        in_valid = 1; i_inst = mk(5'd0, 5'd0, 16'h0); qa = 32'h1234;
        exe_reg = 0; exe_write_regfile = 1; exe_result = 32'hFFFF;
        tick();
        n_cmp++; if (out_da !== 32'd0) begin n_fail++; $display("FAIL r0_never_fwd: got %h want 0", out_da); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        in_valid = 1; i_inst = mk(5'd1, 5'd4, 16'h0); i_use_rt = 1;
        exe_reg = 4; exe_write_regfile = 1; exe_mem_to_regfile = 1; exe_result = 32'hDEAD;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL lu_cnt_before: got %0d want 0", stall_cnt); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: got %b want 0", out_valid); end
        n_cmp++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt_after: got %0d want 1", stall_cnt); end
        exe_reg = 2; exe_mem_to_regfile = 0; exe_write_regfile = 0;
        mem_reg = 4; mem_write_regfile = 1; mem_result = 32'hABCD;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_release: got %b want 1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_db !== 32'hABCD) begin n_fail++; $display("FAIL lu_mem_db: got v=%b %h want v=1 abcd", out_valid, out_db); end
        n_cmp++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt_hold: got %0d want 1", stall_cnt); end
    endtask

    task automatic test_branch();
        clear_inputs();
        in_valid = 1; i_branch = 1; i_inst = mk(5'd1, 5'd2, 16'hFFFF); i_sext = 1;
        qa = 32'h10; qb = 32'h10; i_pc = 32'h100;
        #1;
        n_cmp++; if (branch_taken !== 1'b1) begin n_fail++; $display("FAIL beq_taken: got %b want 1", branch_taken); end
        n_cmp++; if (bpc !== 32'h100) begin n_fail++; $display("FAIL beq_bpc: got %h want 100", bpc); end
        i_bne = 1;
        #1;
        n_cmp++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL bne_equal: got %b want 0", branch_taken); end
        i_bne = 0; flush = 1;
        #1;
        n_cmp++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL beq_flush: got %b want 0", branch_taken); end
        flush = 0; i_pc = 32'hFFFFFFFC; i_inst = mk(5'd1, 5'd2, 16'h0);
        #1;
        n_cmp++; if (bpc !== 32'h0) begin n_fail++; $display("FAIL bpc_wrap: got %h want 0", bpc); end
        clear_inputs();
    endtask

    task automatic test_backpressure_flush();
        clear_inputs();
        tick();
        in_valid = 1; out_ready = 0; i_inst = mk(5'd1, 5'd2, 16'h0); qa = 32'h11; qb = 32'h22; i_pc = 32'h200;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_da !== 32'h11) begin n_fail++; $display("FAIL bp_load: got v=%b %h want v=1 11", out_valid, out_da); end
        qa = 32'h99; qb = 32'h98; i_pc = 32'h300;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready%0d: got %b want 0", k, in_ready); end
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_da !== 32'h11 || out_db !== 32'h22 || out_pc !== 32'h200)
                begin n_fail++; $display("FAIL bp_hold%0d: got v=%b %h %h %h want v=1 11 22 200", k, out_valid, out_da, out_db, out_pc); end
        end
        flush = 1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill: got %b want 0", out_valid); end
        clear_inputs();
    endtask

    task automatic test_stall_saturate();
        clear_inputs();
        #2 reset = 0;
        #2 reset = 1;
        in_valid = 1; i_inst = mk(5'd8, 5'd0, 16'h0); i_use_rs = 1;
        exe_reg = 8; exe_write_regfile = 1; exe_mem_to_regfile = 1;
        for (int k = 0; k < 5; k++) tick();
        n_cmp++; if (stall_cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_cnt2: got %0d want 3", stall_cnt2); end
        n_cmp++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL cnt16_five: got %0d want 5", stall_cnt); end
        #2 reset = 0;
        #1;
        n_cmp++; if (stall_cnt2 !== 2'd0 || stall_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt_async_clr: got %0d/%0d want 0/0", stall_cnt2, stall_cnt); end
        #2 reset = 1;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_backpressure_flush();
        test_stall_saturate();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
